// File: rtl/ntt_ctrl_if.sv
// Control bundle between the NTT sequencer and its datapath: start/abort requests in,
// buffer read, row-calc beat, capture strobes and status out.
interface ntt_ctrl_if #(
  parameter int AW = 6
);
  logic          start;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          mac_en;
  logic          mac_first;
  logic          mac_last;
  logic          y_we;
  logic          busy;
  logic          done;
  logic [15:0]   frame_cnt;

  modport master (
    output start, abort,
    input  rd_en, rd_addr, mac_en, mac_first, mac_last, y_we, busy, done, frame_cnt
  );

  modport slave (
    input  start, abort,
    output rd_en, rd_addr, mac_en, mac_first, mac_last, y_we, busy, done, frame_cnt
  );
endinterface

// File: rtl/ntt_ctrl.sv
// NTT sequencer: N read beats, LAT-cycle drain, one y capture, then a done pulse (done at N+2+LAT after start).
// No backpressure: start is honoured only in IDLE and never queued; abort drops the transform at once.
module ntt_ctrl #(
  parameter int N   = 64,
  parameter int AW  = 6,
  parameter int LAT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  ntt_ctrl_if.slave  io_bus
);

  if (2**AW != N) begin : g_bad_aw
    $error("ntt_ctrl: 2**AW must equal N");
  end
  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("ntt_ctrl: LAT must be in 1..15");
  end

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [3:0]    LAST_DRN  = 4'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_CAPTURE, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_rd_addr;
  logic [3:0]    r_drain;
  logic          r_mac_en;
  logic          r_mac_first;
  logic          r_mac_last;
  logic [15:0]   r_frame_cnt;
  logic          w_rd_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // abort wins over start in IDLE and cancels every active state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (io_bus.start && !io_bus.abort) w_next = S_ISSUE;
      S_ISSUE:   if (io_bus.abort) w_next = S_IDLE;
                 else if (r_rd_addr == LAST_ADDR) w_next = S_DRAIN;
      S_DRAIN:   if (io_bus.abort) w_next = S_IDLE;
                 else if (r_drain == LAST_DRN) w_next = S_CAPTURE;
      S_CAPTURE: w_next = io_bus.abort ? S_IDLE : S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en      = (r_state == S_ISSUE);
    io_bus.rd_en = w_rd_en;
    io_bus.y_we  = (r_state == S_CAPTURE);
    io_bus.done  = (r_state == S_DONE);
    io_bus.busy  = (r_state != S_IDLE);
  end

  // beats already in flight are squashed by abort so the row-calc never sees a partial mac_last
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr   <= '0;
      r_drain     <= '0;
      r_mac_en    <= 1'b0;
      r_mac_first <= 1'b0;
      r_mac_last  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_mac_en    <= w_rd_en && !io_bus.abort;
      r_mac_first <= w_rd_en && !io_bus.abort && (r_rd_addr == '0);
      r_mac_last  <= w_rd_en && !io_bus.abort && (r_rd_addr == LAST_ADDR);
      if (r_state == S_IDLE && w_next == S_ISSUE)
        r_rd_addr <= '0;
      else if (r_state == S_ISSUE && w_next == S_ISSUE)
        r_rd_addr <= r_rd_addr + 1'b1;
      r_drain <= (r_state == S_DRAIN) ? r_drain + 4'd1 : 4'd0;
      if (r_state == S_DONE)
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign io_bus.rd_addr   = r_rd_addr;
  assign io_bus.mac_en    = r_mac_en;
  assign io_bus.mac_first = r_mac_first;
  assign io_bus.mac_last  = r_mac_last;
  assign io_bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: main instance N=64/LAT=8 plus a LAT=1 instance.
// Expected y_we/done cycles are queued at each start and popped as the strobes appear.
module tb_ntt_ctrl;
  localparam int N   = 64;
  localparam int AW  = 6;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_ctrl_if #(.AW(AW)) bus  ();
  ntt_ctrl_if #(.AW(AW)) bus1 ();

  ntt_ctrl #(.N(N), .AW(AW), .LAT(LAT)) u_dut  (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  ntt_ctrl #(.N(N), .AW(AW), .LAT(1))   u_dut1 (.i_clk(clk), .i_rst(rst), .io_bus(bus1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  int q_we[$];
  int q_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cyc - c0 < k) @(negedge clk);
  endtask

  task automatic expect_txn();
    q_we.push_back(c0 + N + 1 + LAT);
    q_done.push_back(c0 + N + 2 + LAT);
  endtask

  // scoreboard side: every strobe must match the next queued cycle
  always @(negedge clk) begin
    if (bus.y_we === 1'b1) begin
      if (q_we.size() == 0) check("y_we_unexpected", q_we.size(), 1);
      else                  check("y_we_cycle", cyc, q_we.pop_front());
    end
    if (bus.done === 1'b1) begin
      if (q_done.size() == 0) check("done_unexpected", q_done.size(), 1);
      else                    check("done_cycle", cyc, q_done.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_mac_en", bus.mac_en, 0);
    check("rst_mac_first", bus.mac_first, 0);
    check("rst_mac_last", bus.mac_last, 0);
    check("rst_y_we", bus.y_we, 0);
    check("rst_done", bus.done, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_busy1", bus1.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // single transform
    c0 = cyc; bus.start = 1'b1; expect_txn();
    goto(1); bus.start = 1'b0;
    check("single_mac_en_c1", bus.mac_en, 0);
    for (int k = 1; k <= N; k++) begin
      goto(k);
      check("single_rd_en", bus.rd_en, 1);
      check("single_rd_addr", bus.rd_addr, k - 1);
      if (k == 2) check("single_mac_first", bus.mac_first, 1);
      if (k == 3) check("single_mac_first_c3", bus.mac_first, 0);
    end
    goto(N + 1);
    check("single_rd_en_off", bus.rd_en, 0);
    check("single_mac_last", bus.mac_last, 1);
    check("single_mac_en_last", bus.mac_en, 1);
    check("single_rd_addr_hold", bus.rd_addr, N - 1);
    goto(N + 2);
    check("single_mac_en_off", bus.mac_en, 0);
    check("single_busy_drain", bus.busy, 1);
    goto(N + 2 + LAT);
    check("single_busy_done", bus.busy, 1);
    goto(N + 3 + LAT);
    check("single_busy_idle", bus.busy, 0);
    check("single_frame_cnt", bus.frame_cnt, 1);

    // back-to-back with start held high
    c0 = cyc; bus.start = 1'b1;
    q_we.push_back(c0 + 73);  q_we.push_back(c0 + 148);
    q_done.push_back(c0 + 74); q_done.push_back(c0 + 149);
    goto(75);
    check("b2b_rd_en_c75", bus.rd_en, 0);
    check("b2b_busy_c75", bus.busy, 0);
    goto(76);
    check("b2b_rd_en_c76", bus.rd_en, 1);
    check("b2b_rd_addr_c76", bus.rd_addr, 0);
    goto(80); bus.start = 1'b0;
    goto(150);
    check("b2b_busy_end", bus.busy, 0);
    check("b2b_frame_cnt", bus.frame_cnt, 3);

    // abort at cycle 30 with a beat in flight
    c0 = cyc; bus.start = 1'b1;
    goto(1); bus.start = 1'b0;
    goto(30);
    check("abort_mac_en_c30", bus.mac_en, 1);
    bus.abort = 1'b1;
    goto(31); bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_rd_en", bus.rd_en, 0);
    check("abort_mac_en", bus.mac_en, 0);
    goto(90);
    check("abort_frame_cnt", bus.frame_cnt, 3);

    // abort on the final read squashes mac_last
    c0 = cyc; bus.start = 1'b1;
    goto(1); bus.start = 1'b0;
    goto(N); bus.abort = 1'b1;
    goto(N + 1); bus.abort = 1'b0;
    check("abort_last_mac_last", bus.mac_last, 0);
    check("abort_last_mac_en", bus.mac_en, 0);
    goto(90);
    check("abort_last_frame_cnt", bus.frame_cnt, 3);

    // normal run after aborts
    c0 = cyc; bus.start = 1'b1; expect_txn();
    goto(1); bus.start = 1'b0;
    goto(N + 3 + LAT);
    check("post_abort_frame_cnt", bus.frame_cnt, 4);

    // reset during DRAIN
    c0 = cyc; bus.start = 1'b1;
    goto(1); bus.start = 1'b0;
    goto(68); rst = 1'b1;
    goto(69); rst = 1'b0;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_rd_en", bus.rd_en, 0);
    check("rstmid_mac_en", bus.mac_en, 0);
    check("rstmid_y_we", bus.y_we, 0);
    check("rstmid_done", bus.done, 0);
    check("rstmid_frame_cnt", bus.frame_cnt, 0);
    check("rstmid_rd_addr", bus.rd_addr, 0);
    goto(90);

    // start with abort in IDLE
    c0 = cyc; bus.start = 1'b1; bus.abort = 1'b1;
    goto(1); bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);
    goto(2);
    check("start_abort_rd_en", bus.rd_en, 0);

    // start while busy is dropped
    c0 = cyc; bus.start = 1'b1; expect_txn();
    goto(1); bus.start = 1'b0;
    goto(10); bus.start = 1'b1;
    goto(11); bus.start = 1'b0;
    goto(N + 3 + LAT);
    check("ignored_frame_cnt", bus.frame_cnt, 1);
    goto(N + 6 + LAT);
    check("ignored_busy", bus.busy, 0);

    // frame counter wrap
    force u_dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release u_dut.r_frame_cnt;
    @(negedge clk);
    check("wrap_preload", bus.frame_cnt, 16'hFFFF);
    c0 = cyc; bus.start = 1'b1; expect_txn();
    goto(1); bus.start = 1'b0;
    goto(N + 3 + LAT);
    check("wrap_frame_cnt", bus.frame_cnt, 0);

    // LAT=1 instance
    c0 = cyc; bus1.start = 1'b1;
    goto(1); bus1.start = 1'b0;
    goto(N + 1);
    check("lat1_mac_last", bus1.mac_last, 1);
    check("lat1_y_we_c65", bus1.y_we, 0);
    goto(N + 2);
    check("lat1_y_we_c66", bus1.y_we, 1);
    check("lat1_done_c66", bus1.done, 0);
    goto(N + 3);
    check("lat1_done_c67", bus1.done, 1);
    check("lat1_y_we_c67", bus1.y_we, 0);
    goto(N + 4);
    check("lat1_busy_c68", bus1.busy, 0);
    check("lat1_frame_cnt", bus1.frame_cnt, 1);

    check("pending_y_we", q_we.size(), 0);
    check("pending_done", q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 Parameter N, default 64: transform length, i.e. the number of input beats per transform.
REQ-002 Parameter AW, default 6: address width; the design SHALL require 2**AW == N.
REQ-003 Parameter LAT, default 8: pipeline latency of the row-calc array, in cycles from the last mac_en to a valid result; legal range 1..15.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a transform; sampled only in IDLE.
REQ-007 abort  input  1  cancel the transform in progress.
REQ-008 rd_en  output  1  read strobe for the x buffer and twiddle ROM.
REQ-009 rd_addr  output  AW  x index and twiddle column index for the current read.
REQ-010 mac_en  output  1  operand beat valid at the row-calc inputs (read data plus 1 cycle).
REQ-011 mac_first  output  1  first beat of a transform; row-calc clears its accumulators.
REQ-012 mac_last  output  1  final beat of a transform.
REQ-013 y_we  output  1  one-cycle strobe that captures all row-calc outputs into y.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a transform has completed.
REQ-016 frame_cnt  output  16  count of completed transforms; wraps modulo 2**16.

Function
REQ-017 State machine states SHALL be IDLE, ISSUE, DRAIN, CAPTURE and DONE.
REQ-018 IDLE -> ISSUE when start=1 and abort=0; rd_addr is loaded with 0 on this transition.
REQ-019 In ISSUE: rd_en=1, rd_addr increments by 1 per cycle from 0 to N-1; the FSM leaves ISSUE after the cycle with rd_addr=N-1 (exactly N cycles).
REQ-020 mac_en, mac_first and mac_last SHALL be rd_en, (rd_en and rd_addr==0) and (rd_en and rd_addr==N-1), each registered by one cycle.
REQ-021 ISSUE -> DRAIN; a drain counter then runs so that the FSM enters CAPTURE exactly LAT cycles after the mac_last cycle.
REQ-022 In CAPTURE, y_we=1 for exactly one cycle; the FSM then moves to DONE.
REQ-023 In DONE: done=1 for one cycle, frame_cnt increments by 1, and the FSM returns to IDLE.
REQ-024 Timing with start sampled at cycle 0: rd_en is high in cycles 1..N; mac_en in 2..N+1; mac_last at N+1; y_we at N+1+LAT; done at N+2+LAT.
REQ-025 busy is high from cycle 1 through the done cycle inclusive; a new start is accepted no earlier than cycle N+3+LAT.
REQ-026 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 abort=1 in any non-IDLE state: the next state is IDLE, and all strobes go low the following cycle, including mac_en and mac_last in flight.
REQ-028 On abort, no y_we and no done are issued, and frame_cnt is unchanged.
REQ-029 start=1 and abort=1 together in IDLE: abort wins and the FSM stays in IDLE.
REQ-030 rd_addr SHALL hold its last value when rd_en=0; it never exceeds N-1 during ISSUE.
REQ-031 frame_cnt at 16'hFFFF followed by a completed transform SHALL read 16'h0000.

Reset
REQ-032 rst=1 at a rising edge forces state IDLE and sets rd_en, mac_en, mac_first, mac_last, y_we, busy and done to 0.
REQ-033 The same rst edge clears rd_addr, the drain counter and frame_cnt to 0.
REQ-034 rst takes priority over start and abort in every state.
REQ-035 rst asserted mid-transform SHALL produce no y_we and no done for that transform.

Verification
REQ-036 Single transform, N=64, LAT=8: start pulse at cycle 0 -> rd_en cycles 1..64 with rd_addr 0..63; mac_first at 2; mac_last at 65; y_we at 73; done at 74; frame_cnt=1.
REQ-037 Back-to-back: start held high continuously -> second rd_en burst begins at cycle 76; done pulses at 74 and 149; frame_cnt=2.
REQ-038 Abort at cycle 30 -> busy=0 and rd_en=0 from cycle 31; no y_we and no done; frame_cnt unchanged; a following start runs normally.
REQ-039 rst during DRAIN (cycle 68) -> all outputs 0 at cycle 69; frame_cnt=0; no done.
REQ-040 start and abort together in IDLE -> busy stays 0; start while busy -> ignored, and only one done is produced.
REQ-041 frame_cnt preloaded by running 65535 transforms (or by a backdoor force) -> one further completion reads 0; LAT=1 variant -> y_we at cycle 66, done at 67.
